ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
Writer-side front end for the dual-read/single-write program RAM. It receives a byte stream (length, big-endian 16-bit words, XOR checksum) over a valid/ready byte interface. It assembles each pair of bytes into a word and drives the RAM write port (address, data, write enable) starting at address 0. While loading it holds the CPU via cpu_hold, so the CPU can be booted with new contents instead of relying on hardcoded initial values.

Parameters:
ADDR_WIDTH, 6, RAM address width; must match the RAM instance
DATA_WIDTH, 16, RAM word width; fixed at 16 (two bytes per word, high byte first)
RAM_DEPTH, 1 << ADDR_WIDTH, maximum number of words in one load

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE
byte_data  in  8  incoming stream byte
byte_valid  in  1  byte_data is valid
byte_ready  out  1  loader accepts a byte this cycle (transfer = byte_valid & byte_ready at posedge)
ram_addr  out  ADDR_WIDTH  RAM write address (to addr_b)
ram_data  out  DATA_WIDTH  RAM write data (to in_data)
ram_we  out  1  RAM write enable (to write_en)
busy  out  1  load in progress
cpu_hold  out  1  stall request to the CPU; equals busy
done  out  1  load finished; held high until the next accepted start
err  out  2  bit0 = checksum mismatch, bit1 = length error; valid while done=1

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs are 0: ram_addr, ram_data, ram_we, byte_ready, busy, cpu_hold, done, err. The word index, remaining count, checksum and high-byte register are also cleared. Reset mid-load aborts the load immediately; the RAM keeps whatever words were already written.
- All outputs are registered.
- States: IDLE, LEN, HI, LO, WRITE, CHK, DONE.
- IDLE/DONE: byte_ready=0. When start=1, go to LEN, clear done/err/index/checksum, and set busy=1.
- start while busy: ignored.
- LEN: byte_ready=1. The accepted byte is L (word count).
  - L > RAM_DEPTH: set err[1], go to DONE, no writes.
  - L = 0: go to CHK.
  - Otherwise: remaining = L, go to HI.
- HI: byte_ready=1. Store the accepted byte as the high byte, xor it into the checksum, go to LO.
- LO: byte_ready=1. xor the accepted byte into the checksum, load ram_data = {hi, byte}, ram_addr = index, and set ram_we=1 for the next cycle. Go to WRITE.
- WRITE: byte_ready=0 and ram_we=1 for exactly one cycle; the RAM captures the word at the end of this cycle. On exit:
  - ram_we=0, index+1, remaining-1.
  - If remaining reaches 0, go to CHK; otherwise go to HI.
- Throughput: at most one word per 3 cycles. byte_valid may be held or gapped freely; no byte is consumed outside accepting states.
- CHK: byte_ready=1. The accepted byte is compared to the running XOR of all data bytes (the length byte is excluded). Mismatch sets err[0]. Go to DONE.
- DONE entry: busy=0, cpu_hold=0, done=1. ram_addr and ram_data hold their last values.
- Index wrap: index is ADDR_WIDTH bits. L=RAM_DEPTH writes addresses 0..RAM_DEPTH-1 exactly once, and the index wraps to 0 only after the final write (unused).
- The length error is decided on the LEN byte alone; the checksum is not read in that case.
- byte_valid with start in the same cycle while in IDLE/DONE: the byte is not accepted (byte_ready=0).

Test Plan:
- Reset then start; stream 02,12,34,AB,CD,(12^34^AB^CD=40) -> ram_we pulses at addr 0 with 1234 and at addr 1 with ABCD, each for one cycle; done=1, err=00, busy/cpu_hold low after the checksum byte.
- Same stream with checksum 41 -> both words written; done=1, err=01.
- Start, length byte 41 (65 > 64) -> no ram_we, done=1, err=10, next byte_ready=0.
- Length 40 (64 words) with data word i = i, correct checksum -> 64 writes at addresses 00..3F in order, last write 003F at addr 3F, err=00.
- Stream 01,55,AA,FF with byte_valid toggling every other cycle and a second start pulse mid-load -> a single write of 55AA at addr 0; the second start is ignored; err=00.
- Assert rst_n low during WRITE of word 1 of a 3-word load -> all outputs 0 asynchronously; after release byte_ready=0 until start; a new load 01,00,07,07 writes 0007 to addr 0.

Source files
------------

// File: rtl/ram_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader_if
//  Description : Byte-stream and RAM write-port bundle for ram_loader.
//                master : byte source / RAM side (drives bytes, sees writes)
//                slave  : the loader (accepts bytes, drives the RAM port)
//                Signals:
//                  byte_data  [7:0]            incoming stream byte
//                  byte_valid                  byte_data is valid
//                  byte_ready                  loader accepts a byte
//                  ram_addr   [ADDR_WIDTH-1:0] RAM write address
//                  ram_data   [DATA_WIDTH-1:0] RAM write data
//                  ram_we                      RAM write enable
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_loader_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_we;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  ram_addr,
        input  ram_data,
        input  ram_we
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output ram_addr,
        output ram_data,
        output ram_we
    );
endinterface
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader
//  Description : Writer-side front end for the program RAM. Receives a byte
//                stream (length L, L big-endian 16-bit words, XOR checksum of
//                the data bytes), writes the words to RAM from address 0 and
//                holds the CPU while loading.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - asynchronous active-low reset
//                start    - one-cycle load request (honoured in IDLE/DONE)
//                bus      - ram_loader_if.slave (byte stream + RAM write port)
//                busy     - load in progress
//                cpu_hold - CPU stall request, equal to busy
//                done     - load finished, held until next accepted start
//                err      - bit0 checksum mismatch, bit1 length error
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       start,
    ram_loader_if.slave     bus,
    output logic            busy,
    output logic            cpu_hold,
    output logic            done,
    output logic [1:0]      err
);

    // Remaining-word counter must hold RAM_DEPTH itself, hence the +1.
    localparam int CNT_W = $clog2(RAM_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                r_state,     w_state;
    logic [ADDR_WIDTH-1:0] r_index,     w_index;
    logic [CNT_W-1:0]      r_remaining, w_remaining;
    logic [7:0]            r_chk,       w_chk;
    logic [7:0]            r_hi,        w_hi;
    logic [ADDR_WIDTH-1:0] r_addr,      w_addr;
    logic [DATA_WIDTH-1:0] r_data,      w_data;
    logic                  r_we,        w_we;
    logic                  r_ready,     w_ready;
    logic                  r_busy,      w_busy;
    logic                  r_done,      w_done;
    logic [1:0]            r_err,       w_err;
    logic                  w_xfer;

    // byte_ready is registered, so a transfer is the registered ready
    // qualified by the source's valid.
    assign w_xfer = bus.byte_valid & r_ready;

    always_comb begin
        w_state     = r_state;
        w_index     = r_index;
        w_remaining = r_remaining;
        w_chk       = r_chk;
        w_hi        = r_hi;
        w_addr      = r_addr;
        w_data      = r_data;
        w_err       = r_err;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state = S_LEN;
                    w_err   = 2'b00;
                    w_index = '0;
                    w_chk   = 8'h00;
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    // Length error is decided on this byte alone; the
                    // remainder of the stream is never consumed.
                    if ({24'd0, bus.byte_data} > $unsigned(RAM_DEPTH)) begin
                        w_err[1] = 1'b1;
                        w_state  = S_DONE;
                    end else if (bus.byte_data == 8'h00) begin
                        w_state = S_CHK;
                    end else begin
                        w_remaining = CNT_W'(bus.byte_data);
                        w_state     = S_HI;
                    end
                end
            end
            S_HI: begin
                if (w_xfer) begin
                    w_hi    = bus.byte_data;
                    w_chk   = r_chk ^ bus.byte_data;
                    w_state = S_LO;
                end
            end
            S_LO: begin
                if (w_xfer) begin
                    w_chk   = r_chk ^ bus.byte_data;
                    w_data  = DATA_WIDTH'({r_hi, bus.byte_data});
                    w_addr  = r_index;
                    w_state = S_WRITE;
                end
            end
            S_WRITE: begin
                // Index wraps to 0 only after the last word of a full load.
                w_index     = r_index + 1'b1;
                w_remaining = r_remaining - 1'b1;
                w_state     = (r_remaining == CNT_W'(1)) ? S_CHK : S_HI;
            end
            S_CHK: begin
                if (w_xfer) begin
                    if (bus.byte_data != r_chk) begin
                        w_err[0] = 1'b1;
                    end
                    w_state = S_DONE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        w_ready = (w_state == S_LEN) || (w_state == S_HI) ||
                  (w_state == S_LO)  || (w_state == S_CHK);
        w_we    = (w_state == S_WRITE);
        w_busy  = (w_state != S_IDLE) && (w_state != S_DONE);
        w_done  = (w_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_remaining <= '0;
            r_chk       <= 8'h00;
            r_hi        <= 8'h00;
            r_addr      <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 2'b00;
        end else begin
            r_state     <= w_state;
            r_index     <= w_index;
            r_remaining <= w_remaining;
            r_chk       <= w_chk;
            r_hi        <= w_hi;
            r_addr      <= w_addr;
            r_data      <= w_data;
            r_we        <= w_we;
            r_ready     <= w_ready;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    assign bus.byte_ready = r_ready;
    assign bus.ram_addr   = r_addr;
    assign bus.ram_data   = r_data;
    assign bus.ram_we     = r_we;
    assign busy           = r_busy;
    assign cpu_hold       = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_loader
//  Description : Self-checking bench for ram_loader. Stimulus builds byte
//                streams, a reference model derives the expected RAM writes
//                and final err code into queues, and a monitor pops and
//                compares whenever the DUT writes or finishes a load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_loader;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       cpu_hold;
    logic       done;
    logic [1:0] err;

    ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RAM_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus.slave),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [AW+DW-1:0] exp_wr[$];
    logic [1:0]       exp_res[$];
    logic [7:0]       stream[$];
    logic             prev_we   = 1'b0;
    logic             prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : mon
        logic [AW+DW-1:0] e;
        logic [1:0]       r;
        if (rst_n) begin
            check("hold_eq_busy", 32'(cpu_hold), 32'(busy));
            if (bus.ram_we) begin
                check("we_single_cycle", 32'(prev_we), 32'd0);
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h:%0h required=none",
                             bus.ram_addr, bus.ram_data);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.ram_addr), 32'(e[AW+DW-1:DW]));
                    check("wr_data", 32'(bus.ram_data), 32'(e[DW-1:0]));
                end
            end
            if (done && !prev_done) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=err%0b required=none", err);
                end else begin
                    r = exp_res.pop_front();
                    check("done_err", 32'(err), 32'(r));
                    check("done_busy", 32'(busy), 32'd0);
                    check("done_ready", 32'(bus.byte_ready), 32'd0);
                end
            end
        end
        prev_we   <= bus.ram_we;
        prev_done <= done;
    end

    // ---------------- reference model ----------------
    // Derives expected writes and err from the byte stream alone.
    task automatic model();
        int         len;
        logic [7:0] x;
        len = int'(stream[0]);
        x   = 8'h00;
        if (len > DEPTH) begin
            exp_res.push_back(2'b10);
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_wr.push_back({AW'(i), stream[1+2*i], stream[2+2*i]});
                x = x ^ stream[1+2*i] ^ stream[2+2*i];
            end
            exp_res.push_back({1'b0, stream[1+2*len] != x});
        end
    endtask

    // pattern 0: random words, 1: word i = i
    task automatic make_stream(input int len, input bit corrupt, input int pattern);
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] x;
        stream.delete();
        stream.push_back(8'(len));
        if (len <= DEPTH) begin
            x = 8'h00;
            for (int i = 0; i < len; i++) begin
                hi = (pattern == 1) ? 8'((i >> 8) & 255) : 8'($urandom_range(0, 255));
                lo = (pattern == 1) ? 8'(i & 255)        : 8'($urandom_range(0, 255));
                stream.push_back(hi);
                stream.push_back(lo);
                x = x ^ hi ^ lo;
            end
            stream.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
        end
    endtask

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready0 required=ready1 byte=%0h", b);
            bus.byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    // A byte offered alongside start must not be taken.
    task automatic do_start();
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hEE;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
        idle(1);
    endtask

    // gap_mode 0: back-to-back, 1: idle cycle before every byte, 2: random
    task automatic run_load(input int gap_mode, input bit midstart);
        model();
        do_start();
        for (int k = 0; k < stream.size(); k++) begin
            if (gap_mode == 1)      idle(1);
            else if (gap_mode == 2) idle($urandom_range(0, 2));
            if (midstart && k == 2) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(stream[k]);
        end
        wait_done();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("rst_addr",  32'(bus.ram_addr),   32'd0);
        check("rst_data",  32'(bus.ram_data),   32'd0);
        check("rst_we",    32'(bus.ram_we),     32'd0);
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_busy",  32'(busy),           32'd0);
        check("rst_hold",  32'(cpu_hold),       32'd0);
        check("rst_done",  32'(done),           32'd0);
        check("rst_err",   32'(err),            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Two words, correct then wrong checksum.
        stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run_load(0, 1'b0);
        stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        run_load(0, 1'b0);

        // Length 65 > 64: error, nothing written, no further bytes taken.
        stream = '{8'h41};
        run_load(0, 1'b0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h12;
        for (int i = 0; i < 3; i++) begin
            check("lenerr_ready", 32'(bus.byte_ready), 32'd0);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;

        // Full-depth load, word i = i.
        make_stream(DEPTH, 1'b0, 1);
        run_load(0, 1'b0);

        // Gapped valid with a second start mid-load.
        stream = '{8'h01, 8'h55, 8'hAA, 8'hFF};
        run_load(1, 1'b1);

        // Empty loads.
        stream = '{8'h00, 8'h00};
        run_load(0, 1'b0);
        stream = '{8'h00, 8'h5A};
        run_load(2, 1'b0);

        // Randomised loads.
        for (int r = 0; r < 10; r++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(65, 255))
                                               : int'($urandom_range(1, 20));
            make_stream(len, 1'(($urandom_range(0, 2) == 0)), 0);
            run_load(2, 1'(($urandom_range(0, 3) == 0)));
        end

        // Reset during the WRITE of word 1 of a 3-word load.
        exp_wr.push_back({AW'(0), 16'h1111});
        exp_wr.push_back({AW'(1), 16'h2222});
        do_start();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h22);
        check("mid_we",   32'(bus.ram_we),   32'd1);
        check("mid_addr", 32'(bus.ram_addr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_addr",  32'(bus.ram_addr),   32'd0);
        check("arst_data",  32'(bus.ram_data),   32'd0);
        check("arst_we",    32'(bus.ram_we),     32'd0);
        check("arst_ready", 32'(bus.byte_ready), 32'd0);
        check("arst_busy",  32'(busy),           32'd0);
        check("arst_hold",  32'(cpu_hold),       32'd0);
        check("arst_done",  32'(done),           32'd0);
        check("arst_err",   32'(err),            32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_ready", 32'(bus.byte_ready), 32'd0);
        end
        bus.byte_valid = 1'b0;
        stream = '{8'h01, 8'h00, 8'h07, 8'h07};
        run_load(0, 1'b0);

        idle(3);
        check("wr_queue_empty",  32'(exp_wr.size()),  32'd0);
        check("res_queue_empty", 32'(exp_res.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
